spi_cmd_ctrl: RTL and testbench

Command/register controller that sequences the SPI slave datapath. It runs in the system `clk` domain and interprets each chip-select frame received by the SPI slave as a command byte followed by data bytes. It writes to or reads from a small local register bank and preloads the slave's transmit byte for MISO. It sits between the SPI slave core and system logic, which observes the bank through a local read port.

---
 rtl/spi_pkg.sv | 16 +
 rtl/spi_regbank.sv | 45 ++++
 rtl/spi_cmd_ctrl.sv | 137 +++++++++++++
 tb/tb_spi_cmd_ctrl.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared constants for the SPI command controller: FSM encoding and command fields.
package spi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CMD   = 2'd1,
    ST_WRITE = 2'd2,
    ST_READ  = 2'd3
  } state_t;

  // Bit of the command byte that selects write (1) or read (0)
  localparam int          CMD_WR_BIT    = 7;
  // Byte shifted out on MISO while the command byte is being received
  localparam logic [7:0]  STATUS_MARKER = 8'hA5;

endpackage

// File: rtl/spi_regbank.sv
// Register bank: synchronous write, combinational SPI read port, registered local read port.
module spi_regbank
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  i_rst,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [ADDR_WIDTH-1:0] i_spi_raddr,
  output logic [DATA_WIDTH-1:0] o_spi_rdata,
  input  logic [ADDR_WIDTH-1:0] i_loc_raddr,
  output logic [DATA_WIDTH-1:0] o_loc_rdata
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DEPTH-1:0][DATA_WIDTH-1:0] r_mem;
  logic [DATA_WIDTH-1:0]            r_loc_rdata;

  // Storage array, cleared by reset, written by the SPI path
  always_ff @(posedge clk) begin
    if (!i_rst) begin
      r_mem <= '0;
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Local readback samples the pre-write contents, so a same-cycle write shows up one cycle later
  always_ff @(posedge clk) begin
    if (!i_rst) begin
      r_loc_rdata <= '0;
    end else begin
      r_loc_rdata <= r_mem[i_loc_raddr];
    end
  end

  assign o_spi_rdata = r_mem[i_spi_raddr];
  assign o_loc_rdata = r_loc_rdata;

endmodule

// File: rtl/spi_cmd_ctrl.sv
// SPI command controller: decodes command/data bytes of each CS frame into bank
// writes or MISO preloads. All outputs are registered; each response lands one
// cycle after the event that triggers it.
module spi_cmd_ctrl
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  i_rst,
  input  logic                  i_cs_n,
  input  logic                  i_rx_valid,
  input  logic [DATA_WIDTH-1:0] i_rx_data,
  output logic                  o_tx_load,
  output logic [DATA_WIDTH-1:0] o_tx_data,
  input  logic [ADDR_WIDTH-1:0] i_reg_addr,
  output logic [DATA_WIDTH-1:0] o_reg_rdata,
  output logic                  o_frame_done,
  output logic                  o_wr_strobe
);

  state_t                r_state, w_state_nx;
  logic [ADDR_WIDTH-1:0] r_ptr, w_ptr_nx;
  // Previous CS level; resets low so a frame still active across reset is not re-entered
  logic                  r_cs_q;
  logic                  r_tx_load, w_tx_load_nx;
  logic [DATA_WIDTH-1:0] r_tx_data, w_tx_data_nx;
  logic                  r_frame_done, w_frame_done_nx;
  logic                  r_wr_strobe;
  logic                  w_we;
  logic [ADDR_WIDTH-1:0] w_cmd_addr;
  logic [ADDR_WIDTH-1:0] w_spi_raddr;
  logic [DATA_WIDTH-1:0] w_spi_rdata;

  assign w_cmd_addr = i_rx_data[ADDR_WIDTH-1:0];

  // State register
  always_ff @(posedge clk) begin
    if (!i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  // Next-state, pointer, bank write and next values of the registered outputs
  always_comb begin
    w_state_nx      = r_state;
    w_ptr_nx        = r_ptr;
    w_tx_load_nx    = 1'b0;
    w_tx_data_nx    = r_tx_data;
    w_frame_done_nx = 1'b0;
    w_we            = 1'b0;
    w_spi_raddr     = r_ptr;
    if (r_state == ST_IDLE) begin
      // Only a genuine high-to-low CS edge opens a frame; rx_valid is ignored here
      if (r_cs_q && !i_cs_n) begin
        w_state_nx   = ST_CMD;
        w_tx_load_nx = 1'b1;
        w_tx_data_nx = STATUS_MARKER;
      end
    end else if (i_cs_n) begin
      // Frame end beats a coincident rx_valid: the byte is dropped
      w_state_nx      = ST_IDLE;
      w_frame_done_nx = 1'b1;
    end else if (i_rx_valid) begin
      case (r_state)
        ST_CMD: begin
          if (i_rx_data[CMD_WR_BIT]) begin
            w_state_nx = ST_WRITE;
            w_ptr_nx   = w_cmd_addr;
          end else begin
            // Read the start address directly so the first byte loads without an extra cycle
            w_state_nx   = ST_READ;
            w_spi_raddr  = w_cmd_addr;
            w_tx_load_nx = 1'b1;
            w_tx_data_nx = w_spi_rdata;
            w_ptr_nx     = w_cmd_addr + ADDR_WIDTH'(1);
          end
        end
        ST_WRITE: begin
          w_we     = 1'b1;
          w_ptr_nx = r_ptr + ADDR_WIDTH'(1);
        end
        ST_READ: begin
          w_tx_load_nx = 1'b1;
          w_tx_data_nx = w_spi_rdata;
          w_ptr_nx     = r_ptr + ADDR_WIDTH'(1);
        end
        default: begin
          w_state_nx = ST_IDLE;
        end
      endcase
    end
  end

  // Pointer, CS history and registered strobes/data
  always_ff @(posedge clk) begin
    if (!i_rst) begin
      r_ptr        <= '0;
      r_cs_q       <= 1'b0;
      r_tx_load    <= 1'b0;
      r_tx_data    <= '0;
      r_frame_done <= 1'b0;
      r_wr_strobe  <= 1'b0;
    end else begin
      r_ptr        <= w_ptr_nx;
      r_cs_q       <= i_cs_n;
      r_tx_load    <= w_tx_load_nx;
      r_tx_data    <= w_tx_data_nx;
      r_frame_done <= w_frame_done_nx;
      r_wr_strobe  <= w_we;
    end
  end

  spi_regbank #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_regbank (
    .clk         (clk),
    .i_rst       (i_rst),
    .i_we        (w_we),
    .i_waddr     (r_ptr),
    .i_wdata     (i_rx_data),
    .i_spi_raddr (w_spi_raddr),
    .o_spi_rdata (w_spi_rdata),
    .i_loc_raddr (i_reg_addr),
    .o_loc_rdata (o_reg_rdata)
  );

  assign o_tx_load    = r_tx_load;
  assign o_tx_data    = r_tx_data;
  assign o_frame_done = r_frame_done;
  assign o_wr_strobe  = r_wr_strobe;

endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// Directed bench for spi_cmd_ctrl. Inputs change on the falling edge, outputs
// are sampled on a later falling edge.
module tb_spi_cmd_ctrl;

  logic       clk = 1'b0;
  logic       i_rst;
  logic       i_cs_n;
  logic       i_rx_valid;
  logic [7:0] i_rx_data;
  logic       o_tx_load;
  logic [7:0] o_tx_data;
  logic [2:0] i_reg_addr;
  logic [7:0] o_reg_rdata;
  logic       o_frame_done;
  logic       o_wr_strobe;

  int checks = 0;
  int errors = 0;

  // Event monitors
  logic [7:0] tx_q[$];
  int         n_wr   = 0;
  int         n_done = 0;

  always #5 clk = ~clk;

  spi_cmd_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) dut (
    .clk          (clk),
    .i_rst        (i_rst),
    .i_cs_n       (i_cs_n),
    .i_rx_valid   (i_rx_valid),
    .i_rx_data    (i_rx_data),
    .o_tx_load    (o_tx_load),
    .o_tx_data    (o_tx_data),
    .i_reg_addr   (i_reg_addr),
    .o_reg_rdata  (o_reg_rdata),
    .o_frame_done (o_frame_done),
    .o_wr_strobe  (o_wr_strobe)
  );

  // Record every pulse seen on the falling edge
  always @(negedge clk) begin
    if (o_tx_load)    tx_q.push_back(o_tx_data);
    if (o_wr_strobe)  n_wr++;
    if (o_frame_done) n_done++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    i_rx_valid = 1'b1;
    i_rx_data  = b;
    @(negedge clk);
    i_rx_valid = 1'b0;
    cyc(2);
  endtask

  task automatic cs_low();
    @(negedge clk);
    i_cs_n = 1'b0;
    cyc(2);
  endtask

  task automatic cs_high();
    @(negedge clk);
    i_cs_n = 1'b1;
    cyc(3);
  endtask

  task automatic rd_local(input logic [2:0] a, input logic [7:0] exp, input string tag);
    @(negedge clk);
    i_reg_addr = a;
    @(negedge clk);
    chk(tag, o_reg_rdata, exp);
  endtask

  initial begin
    int b_tx, b_wr, b_done;
    i_rst      = 1'b0;
    i_cs_n     = 1'b1;
    i_rx_valid = 1'b0;
    i_rx_data  = 8'h00;
    i_reg_addr = 3'd0;
    cyc(3);
    chk("rst_tx_load", o_tx_load, 0);
    chk("rst_tx_data", o_tx_data, 8'h00);
    chk("rst_rdata",   o_reg_rdata, 8'h00);
    chk("rst_done",    o_frame_done, 0);
    chk("rst_wr",      o_wr_strobe, 0);
    i_rst = 1'b1;
    cyc(2);

    // CS fall -> status marker one cycle later; CS rise -> single frame_done
    @(negedge clk);
    i_cs_n = 1'b0;
    @(negedge clk);
    chk("t1_load",      o_tx_load, 1);
    chk("t1_marker",    o_tx_data, 8'hA5);
    @(negedge clk);
    chk("t1_load_off",  o_tx_load, 0);
    i_cs_n = 1'b1;
    @(negedge clk);
    chk("t1_done",      o_frame_done, 1);
    @(negedge clk);
    chk("t1_done_off",  o_frame_done, 0);
    cyc(2);

    // Write frame 0x82,0x11,0x22
    b_tx = tx_q.size(); b_wr = n_wr; b_done = n_done;
    cs_low();
    send_byte(8'h82);
    send_byte(8'h11);
    send_byte(8'h22);
    cs_high();
    chk("t2_wr_cnt",   n_wr - b_wr, 2);
    chk("t2_done_cnt", n_done - b_done, 1);
    chk("t2_tx_cnt",   tx_q.size() - b_tx, 1);
    rd_local(3'd2, 8'h11, "t2_bank2");
    rd_local(3'd3, 8'h22, "t2_bank3");

    // Read frame 0x02,0x00,0x00 -> A5, bank[2], bank[3], bank[4]
    b_tx = tx_q.size(); b_wr = n_wr;
    cs_low();
    send_byte(8'h02);
    send_byte(8'h00);
    send_byte(8'h00);
    cs_high();
    chk("t3_tx_cnt", tx_q.size() - b_tx, 4);
    if (tx_q.size() - b_tx == 4) begin
      chk("t3_tx0", tx_q[b_tx],   8'hA5);
      chk("t3_tx1", tx_q[b_tx+1], 8'h11);
      chk("t3_tx2", tx_q[b_tx+2], 8'h22);
      chk("t3_tx3", tx_q[b_tx+3], 8'h00);
    end
    chk("t3_no_wr", n_wr - b_wr, 0);

    // Wrapping write 0x87,0xAA,0xBB; also watch write-to-readback latency at addr 7
    i_reg_addr = 3'd7;
    cs_low();
    send_byte(8'h87);
    @(negedge clk);
    i_rx_valid = 1'b1;
    i_rx_data  = 8'hAA;
    @(negedge clk);
    i_rx_valid = 1'b0;
    chk("t4_wr_strobe", o_wr_strobe, 1);
    chk("t4_old_val",   o_reg_rdata, 8'h00);
    @(negedge clk);
    chk("t4_new_val",   o_reg_rdata, 8'hAA);
    cyc(1);
    send_byte(8'hBB);
    cs_high();
    rd_local(3'd7, 8'hAA, "t4_bank7");
    rd_local(3'd0, 8'hBB, "t4_bank0_wrap");

    // CS rise together with rx_valid during WRITE: byte dropped
    b_wr = n_wr; b_tx = tx_q.size();
    cs_low();
    send_byte(8'h81);
    @(negedge clk);
    i_rx_valid = 1'b1;
    i_rx_data  = 8'h55;
    i_cs_n     = 1'b1;
    @(negedge clk);
    i_rx_valid = 1'b0;
    chk("t5_done",  o_frame_done, 1);
    chk("t5_no_wr", o_wr_strobe, 0);
    cyc(2);
    chk("t5_wr_cnt", n_wr - b_wr, 0);
    chk("t5_tx_cnt", tx_q.size() - b_tx, 1);
    rd_local(3'd1, 8'h00, "t5_bank1");

    // Reset in the middle of a write frame with CS held low
    cs_low();
    send_byte(8'h84);
    send_byte(8'h66);
    @(negedge clk);
    i_rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("t6_tx_load", o_tx_load, 0);
    chk("t6_tx_data", o_tx_data, 8'h00);
    chk("t6_rdata",   o_reg_rdata, 8'h00);
    chk("t6_done",    o_frame_done, 0);
    chk("t6_wr",      o_wr_strobe, 0);
    i_rst = 1'b1;
    b_wr = n_wr; b_tx = tx_q.size(); b_done = n_done;
    cyc(2);
    send_byte(8'h77);
    chk("t6_idle_wr", n_wr - b_wr, 0);
    chk("t6_idle_tx", tx_q.size() - b_tx, 0);
    for (int a = 0; a < 8; a++) begin
      rd_local(3'(a), 8'h00, $sformatf("t6_bank%0d", a));
    end
    cs_high();
    chk("t6_no_done", n_done - b_done, 0);
    @(negedge clk);
    i_cs_n = 1'b0;
    @(negedge clk);
    chk("t6_fresh_load",   o_tx_load, 1);
    chk("t6_fresh_marker", o_tx_data, 8'hA5);
    cs_high();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Safety net so a stuck run still ends with a report
  initial begin
    #200000;
    errors++;
    $display("FAIL timeout got=running exp=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
